// File: rtl/ipf_lcu_sched.sv
// ipf_lcu_sched -- frame-level sequencer for the IPF filter.
//
// Walks the LCUs of a square frame in raster order (lcu_x inner, lcu_y
// outer). For each LCU it reads one configuration word from config memory,
// latches its fields, then streams the LCU's pixels from frame memory into
// the filter. The first burst carries rows 0..2 and each later burst carries
// one row. After every burst the sequencer waits for the filter's busy to
// rise and then fall before issuing more reads. After the last LCU it waits
// for the filter's finish and raises done.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start, frm_size   frame start pulse; LCU size code (0=16, 1=32, 2/3=64)
//   img_rd, img_addr  frame memory read strobe / address (row*IMG_W+col)
//   img_data          frame memory data, valid the cycle after img_rd
//   cfg_rd, cfg_idx   config memory read strobe / LCU index
//   cfg_data          {type, band_pos, wo_class, offset}, valid after cfg_rd
//   in_en, din        pixel stream to the filter
//   ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset   latched config fields
//   lcu_x, lcu_y, lcu_size                              current LCU position/size
//   ipf_busy, ipf_finish                                filter status
//   sched_busy, done                                    sequencer status
//
// Optional build macro IPF_SCHED_STALLCNT_EN adds output stall_cnt[15:0]:
// a saturating count of cycles spent waiting on the filter (WAIT_HI,
// WAIT_LO, FIN_WAIT), cleared on reset and on an accepted start.

module ipf_lcu_sched #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        frm_size,
  output logic              img_rd,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_data,
  output logic              cfg_rd,
  output logic [5:0]        cfg_idx,
  input  logic [23:0]       cfg_data,
  output logic              in_en,
  output logic [7:0]        din,
  output logic [1:0]        ipf_type,
  output logic [4:0]        ipf_band_pos,
  output logic              ipf_wo_class,
  output logic [15:0]       ipf_offset,
  output logic [2:0]        lcu_x,
  output logic [2:0]        lcu_y,
  output logic [1:0]        lcu_size,
  input  logic              ipf_busy,
  input  logic              ipf_finish,
  output logic              sched_busy,
  output logic              done
`ifdef IPF_SCHED_STALLCNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CFG_RD   = 4'd1;
  localparam logic [3:0] S_CFG_LAT  = 4'd2;
  localparam logic [3:0] S_BURST    = 4'd3;
  localparam logic [3:0] S_DRAIN    = 4'd4;
  localparam logic [3:0] S_WAIT_HI  = 4'd5;
  localparam logic [3:0] S_WAIT_LO  = 4'd6;
  localparam logic [3:0] S_FIN_WAIT = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]  r_state;
  logic [1:0]  r_size;
  logic [2:0]  r_lcu_x;
  logic [2:0]  r_lcu_y;
  logic [6:0]  r_row;      // row within the LCU; reaches N after the last burst
  logic [5:0]  r_col;      // column within the LCU
  logic [23:0] r_cfg;
  logic        r_in_en;
  logic        r_done;

  logic              w_idle;
  logic              w_start_ok;
  logic [6:0]        w_n;
  logic [2:0]        w_lmax;
  logic              w_last_col;
  logic              w_burst_end;
  logic              w_last_lcu;
  logic [3:0]        w_shift;
  logic [ADDR_W-1:0] w_pix_row;
  logic [ADDR_W-1:0] w_pix_col;
  logic [ADDR_W-1:0] w_addr;

  assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_ok = start && w_idle;

  // N = 16 << size pixels per LCU side, L-1 = 7 >> size.
  assign w_n        = 7'd16 << r_size;
  assign w_lmax     = 3'd7 >> r_size;
  assign w_last_col = ({1'b0, r_col} == (w_n - 7'd1));
  // The first burst spans rows 0..2, so no burst can end before row 2.
  assign w_burst_end = w_last_col && (r_row >= 7'd2);
  assign w_last_lcu  = (r_lcu_x == w_lmax) && (r_lcu_y == w_lmax);

  // Absolute pixel row/column: LCU origin is lcu * N = lcu << (4 + size).
  assign w_shift   = 4'd4 + {2'b00, r_size};
  assign w_pix_row = (ADDR_W'(r_lcu_y) << w_shift) + ADDR_W'(r_row);
  assign w_pix_col = (ADDR_W'(r_lcu_x) << w_shift) + ADDR_W'(r_col);
  assign w_addr    = w_pix_row * ADDR_W'(IMG_W) + w_pix_col;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_size  <= '0;
      r_lcu_x <= '0;
      r_lcu_y <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_cfg   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state <= S_CFG_RD;
            r_size  <= (frm_size == 2'd3) ? 2'd2 : frm_size;
            r_lcu_x <= '0;
            r_lcu_y <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
          end
        end
        S_CFG_RD: r_state <= S_CFG_LAT;
        S_CFG_LAT: begin
          r_cfg   <= cfg_data;
          r_state <= S_BURST;
        end
        S_BURST: begin
          if (w_last_col) begin
            r_col <= '0;
            r_row <= r_row + 7'd1;
          end else begin
            r_col <= r_col + 6'd1;
          end
          if (w_burst_end) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_WAIT_HI;
        S_WAIT_HI: begin
          if (ipf_busy) r_state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!ipf_busy) begin
            if (r_row != w_n) begin
              r_state <= S_BURST;
            end else if (w_last_lcu) begin
              r_state <= S_FIN_WAIT;
            end else begin
              r_state <= S_CFG_RD;
              r_row   <= '0;
              if (r_lcu_x == w_lmax) begin
                r_lcu_x <= '0;
                r_lcu_y <= r_lcu_y + 3'd1;
              end else begin
                r_lcu_x <= r_lcu_x + 3'd1;
              end
            end
          end
        end
        S_FIN_WAIT: begin
          if (ipf_finish) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pixel pipeline: the read issued in cycle t is presented at t+1, which
  // is also why DRAIN exists -- it carries the last pixel of a burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_in_en <= 1'b0;
    else       r_in_en <= (r_state == S_BURST);
  end

`ifdef IPF_SCHED_STALLCNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (w_start_ok) begin
      r_stall <= '0;
    end else if (((r_state == S_WAIT_HI) || (r_state == S_WAIT_LO) ||
                  (r_state == S_FIN_WAIT)) && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`endif

  assign img_rd       = (r_state == S_BURST);
  assign img_addr     = img_rd ? w_addr : '0;
  assign cfg_rd       = (r_state == S_CFG_RD);
  assign cfg_idx      = ({3'b000, r_lcu_y} << (2'd3 - r_size)) + {3'b000, r_lcu_x};
  assign in_en        = r_in_en;
  // Frame memory data is already registered at its source; gate it so din
  // is quiet whenever no pixel is being presented.
  assign din          = r_in_en ? img_data : 8'h00;
  assign ipf_type     = r_cfg[23:22];
  assign ipf_band_pos = r_cfg[21:17];
  assign ipf_wo_class = r_cfg[16];
  assign ipf_offset   = r_cfg[15:0];
  assign lcu_x        = r_lcu_x;
  assign lcu_y        = r_lcu_y;
  assign lcu_size     = r_size;
  assign sched_busy   = !w_idle;
  assign done         = r_done;

endmodule
